decode_stage_hz: RTL
====================

Name: decode_stage_hz

Overview:
- Parametrised RV32I decode stage with ID/EX pipeline register; successor to the fixed-width single-format decode stage.
- Sits between the fetch/IF-ID register and the execute stage.
- Adds full RV32I opcode decode, all five immediate formats, and an XLEN/NREGS-parametrised register file with write-through bypass.
- Adds a valid bit, stall/flush control and load-use hazard detection.

Parameters:
- XLEN, 32, datapath width for register data, PC and immediates. Legal values: 32 or 64. Immediates are sign-extended to XLEN.
- NREGS, 32, number of architectural registers. Legal values: 32, or 16 (RV32E).
- BYPASS, 1, 1 = a same-cycle writeback is forwarded to the read ports; 0 = reads return the array contents only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- instr_d  in  32  instruction in ID
- pc_d  in  XLEN  PC of instr_d
- pc_plus4_d  in  XLEN  PC+4 of instr_d
- valid_d  in  1  instr_d is a real instruction
- stall_d  in  1  hold the ID/EX register (downstream stall)
- flush_e  in  1  replace the ID/EX contents with a bubble (branch redirect)
- reg_write_w  in  1  writeback enable
- rd_w  in  5  writeback address
- result_w  in  XLEN  writeback data
- load_use_stall  out  1  combinational; fetch and IF/ID must hold while high
- valid_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e, illegal_e  out  1 each  registered control
- result_src_e  out  2  registered; 00 = ALU, 01 = memory, 10 = PC+4
- alu_src_a_e  out  2  registered; 00 = rs1, 01 = PC, 10 = zero
- alu_control_e  out  4  registered ALU operation code
- funct3_e  out  3  registered, for branch compare and load/store size
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  out  XLEN each  registered
- rs1_e, rs2_e, rd_e  out  5 each  registered, for the forwarding unit

Behaviour:
Reset:
- When rst = 0 at a clk edge, every registered output is cleared to 0.
- All NREGS registers are cleared to 0.
- load_use_stall is 0 while rst = 0.

Decode (combinational in ID):
- Opcode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Any other opcode sets illegal = 1 and forces all write/branch/jump controls to 0.
- When NREGS = 16, any used rs1, rs2 or rd field >= 16 also sets illegal = 1.
- Immediates:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All immediates are sign-extended to XLEN from instr[31].
- alu_control encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 passB.
- sub applies only to R-type with funct7[5] = 1; I-ALU funct3 = 000 is always add.
- srl/sra are selected by funct7[5] for both R-type and I-ALU.
- Branches use sub (comparison in EX via funct3_e). Loads, stores, JAL, JALR and AUIPC use add. LUI uses passB.
- alu_src_a: AUIPC = 01; LUI = 10; all others 00.
- JAL and JALR set result_src = 10 and reg_write = 1.

Register file:
- Write at a clk edge when reg_write_w = 1 and rd_w != 0.
- Register x0 always reads 0.
- With BYPASS = 1: if reg_write_w = 1 and rd_w = rs != 0, the read port returns result_w in the same cycle.

Load-use hazard:
- load_use_stall = valid_d & valid_e & (result_src_e == 01) & (rd_e != 0) & ((uses_rs1 & rs1_d == rd_e) | (uses_rs2 & rs2_d == rd_e)).
- uses_rs1 is 0 for LUI, AUIPC and JAL.
- uses_rs2 is 1 only for R, STORE and BRANCH.

ID/EX update priority at each clk edge:
1. rst = 0: clear.
2. flush_e: bubble. valid_e = 0 and all control outputs = 0; data fields are don't-care but are cleared.
3. stall_d: hold all registers.
4. load_use_stall: bubble.
5. Otherwise load decoded values. valid_e = valid_d. If valid_d = 0, all control outputs load 0.

Boundary rules:
- flush_e together with stall_d: flush wins.
- Reset asserted mid-stall: clear on that edge.
- The register file write happens even while the ID/EX register is stalled or flushed.

Latency: 1 cycle from ID to EX outputs.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with random inputs -> every registered output = 0, valid_e = 0; afterwards a read of x5 returns 0.
- Immediates: for each of the following, one cycle later imm_ext_e and alu_control_e match:
  - addi x1,x0,-1 (0xFFF00093) -> imm_ext_e = 0xFFFFFFFF, alu_control_e = 0000.
  - beq x0,x0,-4 (0xFE000EE3) -> imm_ext_e = 0xFFFFFFFC, branch_e = 1, alu_control_e = 0001.
  - lui x2,0x12345 -> imm_ext_e = 0x12345000, alu_src_a_e = 10.
  - jal x1,+2048 -> imm_ext_e = 0x00000800, result_src_e = 10.
- Bypass and x0: in the same cycle drive reg_write_w = 1, rd_w = 3, result_w = 0xDEADBEEF and decode add x4,x3,x0 -> rd1_e = 0xDEADBEEF, rd2_e = 0. A write to rd_w = 0 leaves x0 reading 0.
- Load-use: lw x5,0(x1) followed by add x6,x5,x2 -> load_use_stall = 1 for exactly 1 cycle, one bubble (valid_e = 0) enters EX, then the add enters with rs1_e = 5. Repeat with lw x0 -> no stall.
- Stall/flush priority: stall_d = 1 for 3 cycles -> EX outputs are held unchanged. stall_d = 1 together with flush_e = 1 -> valid_e = 0 on the next edge. Reset asserted during the stall -> all outputs cleared.
- Illegal and RV32E: opcode 0x7F -> illegal_e = 1, reg_write_e = 0, mem_write_e = 0. With NREGS = 16, add x17,x1,x2 -> illegal_e = 1.

Source files
------------

// File: rtl/decode_stage_hz.sv
// RV32I decode stage with ID/EX pipeline register, register file with optional
// write-through bypass, and load-use hazard detection.
module decode_stage_hz #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            valid_d,
  input  logic            stall_d,
  input  logic            flush_e,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            load_use_stall,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            alu_src_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            jalr_e,
  output logic            illegal_e,
  output logic [1:0]      result_src_e,
  output logic [1:0]      alu_src_a_e,
  output logic [3:0]      alu_control_e,
  output logic [2:0]      funct3_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e
);

  localparam int         AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
    logic [1:0]      result_src;
    logic [1:0]      alu_src_a;
    logic [3:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [3:0] alu_op(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7b5);
    logic [3:0] r;
    r = ALU_ADD;
    if (op == OP_R || op == OP_I) begin
      case (f3)
        3'b000:  r = (op == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  r = ALU_SLL;
        3'b010:  r = ALU_SLT;
        3'b011:  r = ALU_SLTU;
        3'b100:  r = ALU_XOR;
        3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  r = ALU_OR;
        default: r = ALU_AND;
      endcase
    end else if (op == OP_BRANCH) begin
      r = ALU_SUB;
    end else if (op == OP_LUI) begin
      r = ALU_PASSB;
    end
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            known, uses_rs1, uses_rs2, uses_rd, regs_bad, illegal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rd1_raw, rd2_raw;
  logic [XLEN-1:0] regs_q [NREGS];
  ex_t             dec, ex_d, ex_q;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];
  assign rd_d   = instr_d[11:7];

  assign known = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                 (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_JAL) ||
                 (opcode == OP_JALR) || (opcode == OP_LUI) || (opcode == OP_AUIPC);
  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign uses_rd  = known && (opcode != OP_STORE) && (opcode != OP_BRANCH);
  // RV32E: any referenced register index at or above 16 is not encodable
  assign regs_bad = (NREGS == 16) &&
                    ((uses_rs1 && rs1_d[4]) || (uses_rs2 && rs2_d[4]) || (uses_rd && rd_d[4]));
  assign illegal  = !known || regs_bad;

  always_comb begin
    case (opcode)
      OP_STORE:         imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      OP_BRANCH:        imm32 = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25],
                                 instr_d[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {instr_d[31:12], 12'b0};
      OP_JAL:           imm32 = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20],
                                 instr_d[30:21], 1'b0};
      default:          imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
    endcase
  end

  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    if (rs1_d != 5'd0 && {1'b0, rs1_d} < NR) rd1_raw = regs_q[rs1_d[AW-1:0]];
    if (rs2_d != 5'd0 && {1'b0, rs2_d} < NR) rd2_raw = regs_q[rs2_d[AW-1:0]];
    if (BYPASS != 0 && reg_write_w && rs1_d != 5'd0 && rd_w == rs1_d) rd1_raw = result_w;
    if (BYPASS != 0 && reg_write_w && rs2_d != 5'd0 && rd_w == rs2_d) rd2_raw = result_w;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_write_w && rd_w != 5'd0 && {1'b0, rd_w} < NR) begin
      regs_q[rd_w[AW-1:0]] <= result_w;
    end
  end

  always_comb begin
    dec          = '0;
    dec.valid    = valid_d;
    dec.funct3   = funct3;
    dec.rd1      = rd1_raw;
    dec.rd2      = rd2_raw;
    dec.imm      = sext32(imm32);
    dec.pc       = pc_d;
    dec.pc_plus4 = pc_plus4_d;
    dec.rs1      = rs1_d;
    dec.rs2      = rs2_d;
    dec.rd       = rd_d;
    if (valid_d) begin
      dec.illegal     = illegal;
      dec.alu_control = alu_op(opcode, funct3, instr_d[30]);
      dec.alu_src     = (opcode != OP_R) && (opcode != OP_BRANCH);
      dec.alu_src_a   = (opcode == OP_AUIPC) ? 2'b01 : (opcode == OP_LUI) ? 2'b10 : 2'b00;
      if (!illegal) begin
        dec.reg_write  = uses_rd;
        dec.mem_write  = (opcode == OP_STORE);
        dec.branch     = (opcode == OP_BRANCH);
        dec.jump       = (opcode == OP_JAL) || (opcode == OP_JALR);
        dec.jalr       = (opcode == OP_JALR);
        dec.result_src = (opcode == OP_LOAD) ? 2'b01 :
                         ((opcode == OP_JAL) || (opcode == OP_JALR)) ? 2'b10 : 2'b00;
      end
    end
  end

  assign load_use_stall = rst && valid_d && ex_q.valid && (ex_q.result_src == 2'b01) &&
                          (ex_q.rd != 5'd0) &&
                          ((uses_rs1 && rs1_d == ex_q.rd) || (uses_rs2 && rs2_d == ex_q.rd));

  always_comb begin
    ex_d = dec;
    if (flush_e)             ex_d = '0;
    else if (stall_d)        ex_d = ex_q;
    else if (load_use_stall) ex_d = '0;
  end

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign valid_e       = ex_q.valid;
  assign reg_write_e   = ex_q.reg_write;
  assign mem_write_e   = ex_q.mem_write;
  assign alu_src_e     = ex_q.alu_src;
  assign branch_e      = ex_q.branch;
  assign jump_e        = ex_q.jump;
  assign jalr_e        = ex_q.jalr;
  assign illegal_e     = ex_q.illegal;
  assign result_src_e  = ex_q.result_src;
  assign alu_src_a_e   = ex_q.alu_src_a;
  assign alu_control_e = ex_q.alu_control;
  assign funct3_e      = ex_q.funct3;
  assign rd1_e         = ex_q.rd1;
  assign rd2_e         = ex_q.rd2;
  assign imm_ext_e     = ex_q.imm;
  assign pc_e          = ex_q.pc;
  assign pc_plus4_e    = ex_q.pc_plus4;
  assign rs1_e         = ex_q.rs1;
  assign rs2_e         = ex_q.rs2;
  assign rd_e          = ex_q.rd;

endmodule
